// File: rtl/fixed_point_diff_accumulator_pkg.sv
// Shared fixed-point definitions: format defaults, the accumulator FSM states,
// and the sign-magnitude <-> two's complement helpers used by the fixed-point
// stages. Helpers work on a 64-bit carrier. Callers size the result with a cast.
package fxp_pkg;

  localparam int FXP_Q     = 8;
  localparam int FXP_N     = 16;
  localparam int FXP_ACC_W = 24;
  localparam int FXP_LEN   = 16;

  typedef enum logic [1:0] {
    ACCUM,
    CONV,
    OUT
  } fxp_state_e;

  typedef struct packed {
    logic        sat;
    logic [63:0] sm;
  } fxp_sm_sat_t;

  // Largest magnitude of a symmetric signed value of the given width: 2^(w-1)-1.
  function automatic logic [63:0] sat_lim(input int width);
    return (64'd1 << (width - 1)) - 64'd1;
  endfunction

  // Sign-magnitude word of the given width -> two's complement. -0 maps to 0.
  function automatic logic [63:0] sm_to_tc(input logic [63:0] sm, input int width);
    logic [63:0] mag;
    logic        neg;
    mag = sm & sat_lim(width);
    neg = ((sm >> (width - 1)) & 64'd1) != 64'd0;
    return (neg && (mag != 64'd0)) ? (~mag + 64'd1) : mag;
  endfunction

  // Sign-extended two's complement -> sign-magnitude of the given width,
  // clipping the magnitude to 2^(width-1)-1. A zero result always has sign 0.
  function automatic fxp_sm_sat_t tc_to_sm_sat(input logic [63:0] tc, input int width);
    fxp_sm_sat_t r;
    logic [63:0] mag;
    logic        neg;
    neg   = tc[63];
    mag   = neg ? (~tc + 64'd1) : tc;
    r.sat = (mag > sat_lim(width));
    if (r.sat) mag = sat_lim(width);
    r.sm  = (neg && (mag != 64'd0)) ? (mag | (64'd1 << (width - 1))) : mag;
    return r;
  endfunction

endpackage

// File: rtl/fixed_point_diff_accumulator_if.sv
// Sample input stream and block result stream of the difference accumulator.
// master: the producer/consumer side; slave: the accumulator.
interface fixed_point_diff_accumulator_if
  import fxp_pkg::*;
#(
  parameter int N = FXP_N
);
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] out_data;
  logic         out_sat;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_sat
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_sat
  );
endinterface

// File: rtl/fixed_point_diff_accumulator_sm_to_tc.sv
// Combinational sign-magnitude (N bits) to two's complement (W bits) converter.
// W must be at least N so every magnitude is representable; -0 becomes 0.
module fxp_sm_to_tc
  import fxp_pkg::*;
#(
  parameter int N = FXP_N,
  parameter int W = FXP_ACC_W
) (
  input  logic [N-1:0] sm_i,
  output logic [W-1:0] tc_o
);
  assign tc_o = W'(sm_to_tc(64'(sm_i), N));
endmodule

// File: rtl/fixed_point_diff_accumulator.sv
// Sums LEN sign-magnitude Q-format differences in a saturating two's complement
// accumulator and hands out one clipped sign-magnitude result per block.
// Pipeline: accept -> S1 (converted sample) -> acc add -> CONV -> OUT.
module fixed_point_diff_accumulator
  import fxp_pkg::*;
#(
  parameter int Q     = FXP_Q,
  parameter int N     = FXP_N,
  parameter int ACC_W = FXP_ACC_W,
  parameter int LEN   = FXP_LEN
) (
  input logic                            clk,
  input logic                            rst,
  input logic                            clear,
  fixed_point_diff_accumulator_if.slave  bus
);
  localparam int                      CW      = $clog2(LEN + 1);
  localparam logic [CW-1:0]           ONE     = CW'(1);
  localparam logic [CW-1:0]           LEN_C   = CW'(LEN);
  localparam logic signed [ACC_W:0]   ACC_MAX = (ACC_W + 1)'(sat_lim(ACC_W));
  localparam logic signed [ACC_W:0]   ACC_MIN = -ACC_MAX;

  // Reject parameter sets the datapath cannot represent.
  if (Q >= N - 1 || ACC_W < N + 1 || LEN < 2 || ACC_W > 63) begin : g_bad_cfg
    $error("fixed_point_diff_accumulator: illegal parameter set");
  end

  fxp_state_e          state_q;
  logic [CW-1:0]       acc_cnt_q, acc_cnt_d, add_cnt_q;
  logic [ACC_W-1:0]    acc_q, acc_d, s1_q, s1_d;
  logic                s1_valid_q, sat_q, add_sat;
  logic                in_ready_q, out_valid_q, out_sat_q;
  logic [N-1:0]        out_data_q;
  logic signed [ACC_W:0] sum, sum_clip;
  fxp_sm_sat_t         conv;
  logic                accept;

  assign accept        = in_ready_q && bus.in_valid && !clear;
  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_sat   = out_sat_q;

  fxp_sm_to_tc #(.N(N), .W(ACC_W)) u_sm_to_tc (
    .sm_i (bus.in_data),
    .tc_o (s1_d)
  );

  // Saturating add of S1 into acc, output conversion, and accept counter.
  always_comb begin
    // NOTE: every output gets a default first, so no path can infer a latch.
    sum      = $signed({acc_q[ACC_W-1], acc_q}) + $signed({s1_q[ACC_W-1], s1_q});
    sum_clip = sum;
    add_sat  = 1'b0;
    if (sum > ACC_MAX) begin
      sum_clip = ACC_MAX;
      add_sat  = 1'b1;
    end else if (sum < ACC_MIN) begin
      sum_clip = ACC_MIN;
      add_sat  = 1'b1;
    end
    acc_d     = ACC_W'(sum_clip);
    conv      = tc_to_sm_sat(64'($signed(acc_q)), N);
    acc_cnt_d = accept ? acc_cnt_q + ONE : acc_cnt_q;
  end

  // Block FSM with registered handshake outputs; clear overrides everything.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: state is updated with non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (rst) begin
      state_q     <= ACCUM;
      acc_cnt_q   <= '0;
      add_cnt_q   <= '0;
      acc_q       <= '0;
      s1_q        <= '0;
      s1_valid_q  <= 1'b0;
      sat_q       <= 1'b0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sat_q   <= 1'b0;
    end else if (clear) begin
      state_q     <= ACCUM;
      acc_cnt_q   <= '0;
      add_cnt_q   <= '0;
      acc_q       <= '0;
      s1_valid_q  <= 1'b0;
      sat_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        ACCUM: begin
          s1_valid_q <= accept;
          if (accept) s1_q <= s1_d;
          acc_cnt_q  <= acc_cnt_d;
          in_ready_q <= (acc_cnt_d < LEN_C);
          if (s1_valid_q) begin
            acc_q     <= acc_d;
            sat_q     <= sat_q | add_sat;
            add_cnt_q <= add_cnt_q + ONE;
            if (add_cnt_q == LEN_C - ONE) state_q <= CONV;
          end
        end
        CONV: begin
          out_data_q  <= N'(conv.sm);
          out_sat_q   <= sat_q | conv.sat;
          out_valid_q <= 1'b1;
          state_q     <= OUT;
        end
        OUT: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            acc_q       <= '0;
            acc_cnt_q   <= '0;
            add_cnt_q   <= '0;
            sat_q       <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= ACCUM;
          end
        end
        default: state_q <= ACCUM;
      endcase
    end
  end
endmodule

// File: tb/tb_fixed_point_diff_accumulator.sv
// Self-checking bench for fixed_point_diff_accumulator (LEN=4, Q=8, N=16, ACC_W=24).
// Directed cases for the documented corner behaviour, then random blocks checked
// against an arithmetic reference model of the block sum.
module tb_fixed_point_diff_accumulator;
  localparam int LEN = 4;
  typedef logic [15:0] blk_t [LEN];

  logic clk = 1'b0;
  logic rst;
  logic clear;
  int   tests = 0;
  int   fails = 0;

  fixed_point_diff_accumulator_if #(.N(16)) bus ();

  fixed_point_diff_accumulator #(
    .Q(8), .N(16), .ACC_W(24), .LEN(LEN)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .clear (clear),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached after %0d tests", tests);
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: signed sum with symmetric clip at +/-(2^23-1), then 15-bit magnitude clip.
  // Returns {sat, sign, magnitude}.
  function automatic logic [16:0] model(input blk_t s);
    longint acc = 0;
    longint mag;
    bit     sat = 1'b0;
    longint lim = (longint'(1) << 23) - 1;
    for (int i = 0; i < LEN; i++) begin
      mag = longint'(s[i][14:0]);
      acc += s[i][15] ? -mag : mag;
      if (acc > lim) begin
        acc = lim; sat = 1'b1;
      end else if (acc < -lim) begin
        acc = -lim; sat = 1'b1;
      end
    end
    mag = (acc < 0) ? -acc : acc;
    if (mag > 32767) begin
      mag = 32767; sat = 1'b1;
    end
    return {sat, (acc < 0), mag[14:0]};
  endfunction

  // Present one sample from the next falling edge until a rising edge accepts it.
  task automatic send(input logic [15:0] d, output bit ok);
    ok = 1'b0;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    for (int i = 0; i < 50; i++) begin
      if (bus.in_ready) begin
        @(posedge clk);
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  // Feed a full block and wait (bounded) for out_valid; checks accept and latency.
  task automatic fill(input string tag, input blk_t s);
    bit ok;
    bit seen;
    int edges;
    for (int i = 0; i < LEN; i++) begin
      send(s[i], ok);
      check({tag, "_accept"}, 32'(ok), 32'd1);
    end
    edges = 0;
    seen  = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
      bus.in_valid = 1'b0;
      seen = bus.out_valid;
    end
    check({tag, "_latency"}, 32'(edges), 32'd2);
  endtask

  // Full block: fill, hold out_ready low for 'stall' cycles with a sample offered,
  // then complete the handshake and check the one-cycle bubble.
  task automatic run_block(input string tag, input blk_t s, input int stall,
                           output logic [15:0] data, output logic sat);
    fill(tag, s);
    data = bus.out_data;
    sat  = bus.out_sat;
    bus.in_valid = 1'b1;
    bus.in_data  = 16'h7000;
    for (int k = 0; k < stall; k++) begin
      @(negedge clk);
      check({tag, "_hold_valid"}, 32'(bus.out_valid), 32'd1);
      check({tag, "_hold_data"},  32'(bus.out_data),  32'(data));
      check({tag, "_hold_sat"},   32'(bus.out_sat),   32'(sat));
      check({tag, "_hold_ready"}, 32'(bus.in_ready),  32'd0);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.out_ready = 1'b0;
    check({tag, "_post_valid"}, 32'(bus.out_valid), 32'd0);
    check({tag, "_post_ready"}, 32'(bus.in_ready),  32'd1);
  endtask

  initial begin
    blk_t        s;
    logic [15:0] d;
    logic        sat;
    logic [16:0] exp;
    bit          ok;

    rst = 1'b1;
    clear = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;

    // Reset values, and in_ready rising only on the first edge after release.
    #1;
    check("rst_in_ready",  32'(bus.in_ready),  32'd0);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_out_data",  32'(bus.out_data),  32'd0);
    check("rst_out_sat",   32'(bus.out_sat),   32'd0);
    repeat (3) @(negedge clk);
    check("rst_hold_ready", 32'(bus.in_ready), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("rst_release_ready", 32'(bus.in_ready), 32'd1);

    // 1 + 1 - 0.5 + 0.25 = 1.75
    s = '{16'h0100, 16'h0100, 16'h8080, 16'h0040};
    run_block("t1", s, 0, d, sat);
    check("t1_data", 32'(d), 32'h01C0);
    check("t1_sat",  32'(sat), 32'd0);

    // Negative zero sums to +0.
    s = '{16'h8000, 16'h8000, 16'h8000, 16'h8000};
    run_block("t2", s, 1, d, sat);
    check("t2_data", 32'(d), 32'h0000);
    check("t2_sat",  32'(sat), 32'd0);

    // Output magnitude clipping, both signs.
    s = '{16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF};
    run_block("t3p", s, 0, d, sat);
    check("t3p_data", 32'(d), 32'h7FFF);
    check("t3p_sat",  32'(sat), 32'd1);
    s = '{16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF};
    run_block("t3n", s, 0, d, sat);
    check("t3n_data", 32'(d), 32'hFFFF);
    check("t3n_sat",  32'(sat), 32'd1);

    // Back-pressure for 5 cycles; the sample offered meanwhile must not leak in.
    s = '{16'h0123, 16'h8010, 16'h0200, 16'h8001};
    run_block("t4", s, 5, d, sat);
    check("t4_data", 32'(d), 32'h0312);
    check("t4_sat",  32'(sat), 32'd0);
    s = '{16'h0100, 16'h0100, 16'h0100, 16'h0100};
    run_block("t4b", s, 0, d, sat);
    check("t4b_data", 32'(d), 32'h0400);

    // clear after two accepts, coincident with an offered sample.
    send(16'h0300, ok);
    check("t5_acc0", 32'(ok), 32'd1);
    send(16'h0300, ok);
    check("t5_acc1", 32'(ok), 32'd1);
    @(negedge clk);
    clear = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_data  = 16'h0500;
    @(posedge clk);
    @(negedge clk);
    clear = 1'b0;
    bus.in_valid = 1'b0;
    check("t5_clr_valid", 32'(bus.out_valid), 32'd0);
    check("t5_clr_ready", 32'(bus.in_ready),  32'd1);
    s = '{16'h0100, 16'h0100, 16'h0100, 16'h0100};
    run_block("t5", s, 0, d, sat);
    check("t5_data", 32'(d), 32'h0400);
    check("t5_sat",  32'(sat), 32'd0);

    // clear beats a simultaneous out_ready and discards the pending result.
    s = '{16'h1000, 16'h1000, 16'h1000, 16'h1000};
    fill("t5o", s);
    bus.out_ready = 1'b1;
    clear = 1'b1;
    @(posedge clk);
    @(negedge clk);
    clear = 1'b0;
    bus.out_ready = 1'b0;
    check("t5o_valid", 32'(bus.out_valid), 32'd0);
    check("t5o_ready", 32'(bus.in_ready),  32'd1);
    s = '{16'h0040, 16'h8010, 16'h0008, 16'h0001};
    exp = model(s);
    run_block("t5o_next", s, 0, d, sat);
    check("t5o_next_data", 32'(d),   32'(exp[15:0]));
    check("t5o_next_sat",  32'(sat), 32'(exp[16]));

    // Asynchronous reset in OUT: outputs drop before the next rising edge.
    s = '{16'h4000, 16'h4000, 16'h4000, 16'h4000};
    fill("t6", s);
    #2 rst = 1'b1;
    #1;
    check("t6_async_valid", 32'(bus.out_valid), 32'd0);
    check("t6_async_data",  32'(bus.out_data),  32'd0);
    check("t6_async_sat",   32'(bus.out_sat),   32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("t6_ready", 32'(bus.in_ready), 32'd1);
    s = '{16'h0200, 16'h8100, 16'h0080, 16'h0011};
    exp = model(s);
    run_block("t6_next", s, 0, d, sat);
    check("t6_next_data", 32'(d),   32'(exp[15:0]));
    check("t6_next_sat",  32'(sat), 32'(exp[16]));

    // Random blocks against the reference model.
    for (int b = 0; b < 24; b++) begin
      for (int i = 0; i < LEN; i++) begin
        if ($urandom_range(0, 3) == 0) s[i] = 16'($urandom);
        else s[i] = {1'($urandom), 15'($urandom_range(0, 2048))};
      end
      exp = model(s);
      run_block("rnd", s, int'($urandom_range(0, 3)), d, sat);
      check("rnd_data", 32'(d),   32'(exp[15:0]));
      check("rnd_sat",  32'(sat), 32'(exp[16]));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
